flag_branch_unit: RTL and testbench

- Consumer side of the ALU flag interface: holds the architectural Z/V/N flag register and resolves conditional branches.
- Applies per-opcode flag-write rules to the EX-stage ALU flag output and forwards same-cycle flag results to the branch in ID.
- Owns the PC register: fetch advance, branch/branch-register redirect, stall hold and the HLT halt state.
- Sits between IF/ID/EX and drives the instruction-memory address and the IF flush.

---
 rtl/flag_branch_unit.sv | 165 ++++++++++++++++
 tb/tb_flag_branch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_branch_unit.sv
// ---------------------------------------------------------------------------
// flag_branch_unit
//
// Holds the architectural Z/V/N flag register and the PC, and resolves
// conditional branches that sit in the ID stage.
//
// Flags are written from the EX-stage ALU output. Which bits are written
// depends on the EX opcode. A flag bit that EX writes in the current cycle is
// bypassed straight into the branch condition, so a branch in ID sees the
// result of the instruction directly ahead of it without waiting a cycle.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset (pc=RESET_PC, flags=0, RUN)
//   stall        hazard stall from ID: holds pc and suppresses any redirect
//   id_valid     ID holds a real instruction (0 = bubble)
//   id_opcode    ID opcode: 1100=B, 1101=BR, 1111=HLT
//   id_cond      branch condition code
//   id_imm9      signed word offset for B
//   id_pc_plus2  PC+2 of the ID instruction (base for B)
//   id_rs_data   forwarded register target for BR
//   ex_valid     EX holds a real instruction
//   ex_opcode    EX opcode (selects which flag bits are written)
//   ex_zvn       ALU flags from EX, [2]=Z [1]=V [0]=N
//   pc           registered fetch address
//   flags        architectural ZVN register
//   branch_taken ID branch redirects this cycle (combinational)
//   flush_if     squash the IF/ID instruction (same as branch_taken)
//   halted       set while in the HALT state
// ---------------------------------------------------------------------------
module flag_branch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        id_valid,
    input  logic [3:0]  id_opcode,
    input  logic [2:0]  id_cond,
    input  logic [8:0]  id_imm9,
    input  logic [15:0] id_pc_plus2,
    input  logic [15:0] id_rs_data,
    input  logic        ex_valid,
    input  logic [3:0]  ex_opcode,
    input  logic [2:0]  ex_zvn,
    output logic [15:0] pc,
    output logic [2:0]  flags,
    output logic        branch_taken,
    output logic        flush_if,
    output logic        halted
);

    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      state_reg;
    logic [15:0] pc_reg;
    logic [2:0]  flags_reg;
    logic        halted_reg;

    logic [2:0]  flag_we;
    logic [2:0]  flags_eff;
    logic        cond_true;
    logic        is_b;
    logic        is_br;
    logic        is_hlt;
    logic        id_go;
    logic        taken;
    logic [15:0] b_target;

    // Per-bit write enables from the EX opcode. Arithmetic ops write all
    // three flags; logic/shift-type ops only write Z.
    always_comb begin
        flag_we = 3'b000;
        if (ex_valid) begin
            case (ex_opcode)
                4'b0000, 4'b0001:                    flag_we = 3'b111;
                4'b0010, 4'b0100, 4'b0101, 4'b0110: flag_we = 3'b100;
                default:                             flag_we = 3'b000;
            endcase
        end
    end

    // Per-bit bypass: a bit written this cycle comes from EX, the rest from
    // the stored register. Partial bypass is intentional.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_flag_bypass
            assign flags_eff[gi] = flag_we[gi] ? ex_zvn[gi] : flags_reg[gi];
        end
    endgenerate

    // Condition evaluation on the effective flags: [2]=Z [1]=V [0]=N.
    always_comb begin
        cond_true = 1'b0;
        case (id_cond)
            3'b000: cond_true = ~flags_eff[2];
            3'b001: cond_true =  flags_eff[2];
            3'b010: cond_true = ~flags_eff[2] & ~flags_eff[0];
            3'b011: cond_true =  flags_eff[0];
            3'b100: cond_true =  flags_eff[2] | (~flags_eff[2] & ~flags_eff[0]);
            3'b101: cond_true =  flags_eff[0] |  flags_eff[2];
            3'b110: cond_true =  flags_eff[1];
            default: cond_true = 1'b1;
        endcase
    end

    assign is_b   = (id_opcode == OP_B);
    assign is_br  = (id_opcode == OP_BR);
    assign is_hlt = (id_opcode == OP_HLT);

    // ID may act only on a real, unstalled instruction while running.
    assign id_go  = (state_reg == ST_RUN) & id_valid & ~stall;
    assign taken  = id_go & (is_b | is_br) & cond_true;

    // Word offset: sign-extend the 9-bit immediate and scale by 2.
    assign b_target = id_pc_plus2 + {{6{id_imm9[8]}}, id_imm9, 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_RUN;
            pc_reg     <= RESET_PC;
            flags_reg  <= 3'b000;
            halted_reg <= 1'b0;
        end else begin
            // Flags follow EX regardless of stall or halt.
            flags_reg <= (flag_we & ex_zvn) | (~flag_we & flags_reg);

            case (state_reg)
                ST_RUN: begin
                    if (stall) begin
                        pc_reg <= pc_reg;
                    end else if (taken) begin
                        pc_reg <= is_b ? b_target : id_rs_data;
                    end else if (id_valid && is_hlt) begin
                        // pc stays on its current value once halted.
                        state_reg  <= ST_HALT;
                        halted_reg <= 1'b1;
                    end else begin
                        pc_reg <= pc_reg + 16'd2;
                    end
                end
                ST_HALT: begin
                    pc_reg <= pc_reg;
                end
                default: begin
                    state_reg  <= ST_RUN;
                    halted_reg <= 1'b0;
                end
            endcase
        end
    end

    assign pc           = pc_reg;
    assign flags        = flags_reg;
    assign halted       = halted_reg;
    assign branch_taken = taken;
    assign flush_if     = taken;

endmodule

// File: tb/tb_flag_branch_unit.sv
// ---------------------------------------------------------------------------
// Self-checking bench for flag_branch_unit: directed scenarios followed by
// randomized traffic, all checked against a behavioural model of the PC,
// flags and halt state kept in this file.
// ---------------------------------------------------------------------------
module tb_flag_branch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        id_valid;
    logic [3:0]  id_opcode;
    logic [2:0]  id_cond;
    logic [8:0]  id_imm9;
    logic [15:0] id_pc_plus2;
    logic [15:0] id_rs_data;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [2:0]  ex_zvn;
    logic [15:0] pc;
    logic [2:0]  flags;
    logic        branch_taken;
    logic        flush_if;
    logic        halted;

    always #5 clk = ~clk;

    flag_branch_unit #(.RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .id_valid     (id_valid),
        .id_opcode    (id_opcode),
        .id_cond      (id_cond),
        .id_imm9      (id_imm9),
        .id_pc_plus2  (id_pc_plus2),
        .id_rs_data   (id_rs_data),
        .ex_valid     (ex_valid),
        .ex_opcode    (ex_opcode),
        .ex_zvn       (ex_zvn),
        .pc           (pc),
        .flags        (flags),
        .branch_taken (branch_taken),
        .flush_if     (flush_if),
        .halted       (halted)
    );

    int tests = 0;
    int fails = 0;

    // Reference state
    int m_pc   = 0;
    bit m_z    = 0;
    bit m_v    = 0;
    bit m_n    = 0;
    bit m_halt = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst         = 1'b0;
        stall       = 1'b0;
        id_valid    = 1'b0;
        id_opcode   = 4'h0;
        id_cond     = 3'b000;
        id_imm9     = 9'h000;
        id_pc_plus2 = 16'h0000;
        id_rs_data  = 16'h0000;
        ex_valid    = 1'b0;
        ex_opcode   = 4'h0;
        ex_zvn      = 3'b000;
    endtask

    // One clock: check the combinational decision mid-cycle, advance the
    // model, then check the registered state just after the edge.
    task automatic cycle(input string tag);
        bit wz, wvn, ez, ev, en, ct, exp_taken;
        int op;
        @(negedge clk);
        op  = int'(ex_opcode);
        wz  = ex_valid && (op == 0 || op == 1 || op == 2 || op == 4 || op == 5 || op == 6);
        wvn = ex_valid && (op == 0 || op == 1);
        ez  = wz  ? ex_zvn[2] : m_z;
        ev  = wvn ? ex_zvn[1] : m_v;
        en  = wvn ? ex_zvn[0] : m_n;
        case (id_cond)
            3'd0: ct = !ez;
            3'd1: ct = ez;
            3'd2: ct = !ez && !en;
            3'd3: ct = en;
            3'd4: ct = ez || (!ez && !en);
            3'd5: ct = en || ez;
            3'd6: ct = ev;
            default: ct = 1;
        endcase
        exp_taken = !m_halt && id_valid && !stall &&
                    (id_opcode == 4'd12 || id_opcode == 4'd13) && ct;
        check({tag, "_taken"}, {15'd0, branch_taken}, {15'd0, exp_taken});
        check({tag, "_flush"}, {15'd0, flush_if}, {15'd0, exp_taken});

        if (rst) begin
            m_pc = 0; m_z = 0; m_v = 0; m_n = 0; m_halt = 0;
        end else begin
            if (wz)  m_z = ex_zvn[2];
            if (wvn) begin m_v = ex_zvn[1]; m_n = ex_zvn[0]; end
            if (!m_halt && !stall) begin
                if (exp_taken) begin
                    if (id_opcode == 4'd12)
                        m_pc = (int'(id_pc_plus2) + 2 * int'($signed(id_imm9))) & 16'hFFFF;
                    else
                        m_pc = int'(id_rs_data);
                end else if (id_valid && id_opcode == 4'd15) begin
                    m_halt = 1;
                end else begin
                    m_pc = (m_pc + 2) % 65536;
                end
            end
        end

        @(posedge clk);
        #1;
        check({tag, "_pc"}, pc, 16'(m_pc));
        check({tag, "_flags"}, {13'd0, flags}, {13'd0, m_z, m_v, m_n});
        check({tag, "_halted"}, {15'd0, halted}, {15'd0, m_halt});
        $display("[TB] %s rst=%0b stall=%0b id=%0b/%h c=%0d ex=%0b/%h zvn=%b -> pc=%h flags=%b taken=%0b halted=%0b",
                 tag, rst, stall, id_valid, id_opcode, id_cond, ex_valid, ex_opcode, ex_zvn,
                 pc, flags, exp_taken, halted);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        cycle("init_rst");

        // Reset with pc away from zero
        idle();
        id_valid = 1'b1; id_opcode = 4'b1101; id_cond = 3'b111; id_rs_data = 16'h0040;
        cycle("br_to_40");
        check("pc_at_40", pc, 16'h0040);
        idle();
        rst = 1'b1;
        cycle("rst_a");
        cycle("rst_b");
        check("rst_pc", pc, 16'h0000);
        check("rst_flags", {13'd0, flags}, 16'h0000);
        check("rst_halted", {15'd0, halted}, 16'h0000);
        rst = 1'b0;
        cycle("seq_2");
        check("seq_pc2", pc, 16'h0002);
        cycle("seq_4");
        check("seq_pc4", pc, 16'h0004);

        // Same-cycle Z forwarding from SUB
        idle();
        ex_valid = 1'b1; ex_opcode = 4'b0001; ex_zvn = 3'b100;
        id_valid = 1'b1; id_opcode = 4'b1100; id_cond = 3'b001;
        id_imm9 = 9'h004; id_pc_plus2 = 16'h0010;
        cycle("fwd");
        check("fwd_pc", pc, 16'h0018);
        check("fwd_flags", {13'd0, flags}, 16'h0004);

        // Partial enable: Z-only writer, branch on stored V
        idle();
        ex_valid = 1'b1; ex_opcode = 4'b0000; ex_zvn = 3'b011;
        cycle("set_011");
        idle();
        ex_valid = 1'b1; ex_opcode = 4'b0010; ex_zvn = 3'b100;
        id_valid = 1'b1; id_opcode = 4'b1100; id_cond = 3'b110;
        id_imm9 = 9'h000; id_pc_plus2 = 16'h0100;
        cycle("partial");
        check("partial_pc", pc, 16'h0100);
        check("partial_flags", {13'd0, flags}, 16'h0007);

        // Negative offset wrapping below zero, then sequential wrap
        idle();
        id_valid = 1'b1; id_opcode = 4'b1100; id_cond = 3'b111;
        id_imm9 = 9'h1FE; id_pc_plus2 = 16'h0002;
        cycle("neg_off");
        check("neg_pc", pc, 16'hFFFE);
        idle();
        cycle("wrap");
        check("wrap_pc", pc, 16'h0000);

        // Stalled BR holds, then redirects
        idle();
        stall = 1'b1;
        id_valid = 1'b1; id_opcode = 4'b1101; id_cond = 3'b111; id_rs_data = 16'h1234;
        cycle("stall_a");
        cycle("stall_b");
        check("stall_pc", pc, 16'h0000);
        stall = 1'b0;
        cycle("unstall");
        check("unstall_pc", pc, 16'h1234);

        // Halt, with flag updates still flowing from EX
        idle();
        id_valid = 1'b1; id_opcode = 4'b1101; id_cond = 3'b111; id_rs_data = 16'h0020;
        cycle("br_to_20");
        idle();
        id_valid = 1'b1; id_opcode = 4'b1111;
        cycle("hlt");
        check("hlt_halted", {15'd0, halted}, 16'h0001);
        check("hlt_pc", pc, 16'h0020);
        idle();
        id_valid = 1'b1; id_opcode = 4'b1100; id_cond = 3'b111;
        id_imm9 = 9'h010; id_pc_plus2 = 16'h0022;
        ex_valid = 1'b1; ex_opcode = 4'b0001; ex_zvn = 3'b010;
        for (int i = 0; i < 10; i++) cycle("halt_hold");
        check("halt_pc", pc, 16'h0020);
        check("halt_flags", {13'd0, flags}, 16'h0002);
        idle();
        rst = 1'b1;
        cycle("halt_rst");
        check("halt_rst_pc", pc, 16'h0000);
        check("halt_rst_halted", {15'd0, halted}, 16'h0000);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            rst         = ($urandom_range(0, 24) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            id_valid    = ($urandom_range(0, 4) != 0);
            r           = $urandom_range(0, 15);
            if (r < 6)       id_opcode = 4'b1100;
            else if (r < 10) id_opcode = 4'b1101;
            else if (r == 10) id_opcode = 4'b1111;
            else             id_opcode = 4'($urandom_range(0, 15));
            id_cond     = 3'($urandom_range(0, 7));
            id_imm9     = 9'($urandom_range(0, 511));
            id_pc_plus2 = 16'($urandom_range(0, 65535));
            id_rs_data  = 16'($urandom_range(0, 65535));
            ex_valid    = ($urandom_range(0, 3) != 0);
            ex_opcode   = 4'($urandom_range(0, 7));
            ex_zvn      = 3'($urandom_range(0, 7));
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
